// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming dot-product MAC engine.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    // Beat-counter width for the default vector length; instances derive theirs via cnt_width().
    localparam int unsigned MAC_LEN = 4;
    localparam int unsigned CNT_W   = $clog2(MAC_LEN + 1);

    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // One accumulation step overflows on carry-out (unsigned) or sign flip of like-signed operands (signed).
    function automatic logic add_ovf(
        input logic is_signed,
        input logic carry,
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        if (is_signed) begin
            return (a_msb == b_msb) && (s_msb != a_msb);
        end
        return carry;
    endfunction

endpackage

// File: rtl/mac_stage.sv
// Stage 1 of the MAC pipeline: registered multiply, extended to the accumulator width.
module mac_stage
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  prod_o,
    output logic              vld_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod_raw_c;
    logic [ACC_W-1:0]  prod_ext_c;
    logic [ACC_W-1:0]  prod_q;
    logic              vld_q;

    generate
        if (SIGNED) begin : g_signed
            always_comb begin
                prod_raw_c = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
                prod_ext_c = ACC_W'($signed(prod_raw_c));
            end
        end else begin : g_unsigned
            always_comb begin
                prod_raw_c = PROD_W'(a_i) * PROD_W'(b_i);
                prod_ext_c = ACC_W'(prod_raw_c);
            end
        end
    endgenerate

    // vld_q marks a product still waiting to be folded into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else if (clear_i) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= load_i;
            if (load_i) begin
                prod_q <= prod_ext_c;
            end
        end
    end

    assign prod_o = prod_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/dot_product_mac.sv
// Streaming dot-product engine: LEN operand pairs per vector accumulated onto a bias.
module dot_product_mac
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned LEN    = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] entry_a,
    input  logic [DATA_W-1:0] entry_b,
    input  logic [ACC_W-1:0]  bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              overflow
);

    localparam int unsigned VEC_CNT_W = cnt_width(LEN);

    state_e               state_q, state_d;
    logic [VEC_CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 beat_c;
    logic                 first_c;
    logic                 last_c;
    logic [ACC_W-1:0]     prod_c;
    logic                 prod_vld_c;
    logic [ACC_W:0]       add_c;
    logic                 step_ovf_c;

    assign beat_c  = (state_q == ST_ACCUM) && in_valid && !clear;
    assign first_c = beat_c && (cnt_q == '0);
    assign last_c  = beat_c && (cnt_q == VEC_CNT_W'(LEN - 1));

    mac_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .load_i  (beat_c),
        .a_i     (entry_a),
        .b_i     (entry_b),
        .prod_o  (prod_c),
        .vld_o   (prod_vld_c)
    );

    assign add_c      = {1'b0, acc_q} + {1'b0, prod_c};
    assign step_ovf_c = add_ovf(SIGNED, add_c[ACC_W], acc_q[ACC_W-1], prod_c[ACC_W-1], add_c[ACC_W-1]);

    // Next-state, accumulator and registered-output decode; clear overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (prod_vld_c) begin
            acc_d = add_c[ACC_W-1:0];
            ovf_d = ovf_q | step_ovf_c;
        end

        case (state_q)
            ST_ACCUM: begin
                if (beat_c) begin
                    cnt_d = cnt_q + VEC_CNT_W'(1);
                    // The previous vector's last product retired in DRAIN, so bias never races an add.
                    if (first_c) begin
                        acc_d = bias;
                        ovf_d = 1'b0;
                    end
                    if (last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        if (clear) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end

        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign overflow  = ovf_q;

endmodule
